irq_sched: RTL
==============

Name: irq_sched

Overview:
- Interrupt scheduler for the mriscvcore execution unit.
- Latches up to N_IRQ external interrupt lines as edges, applies mask and global enable, and picks the highest-priority pending source.
- Runs a request/ack handshake with the core sequencer and supplies the 32-bit interrupt target address for the PC unit's interrupt input.
- Captures the return PC (epc) at acceptance and holds the block in service until the core signals return; no nesting.

Parameters:
- N_IRQ, 8, number of interrupt sources (1..31).
- ID_W, 3, width of source index; must be at least clog2(N_IRQ).
- VEC_BASE, 32'h0000_0100, address of the source-0 handler.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- irq_in  in  N_IRQ  raw interrupt lines; a rising edge marks a source pending.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  1  0 = mask/enable register, 1 = pending register.
- cfg_wdata  in  32  config write data.
- cfg_rdata  out  32  config read data (combinational).
- pc_in  in  32  current PC from the PC unit.
- irq_ack  in  1  core accepts the request at an instruction boundary.
- irq_ret  in  1  core finished the handler (return executed).
- irq_req  out  1  interrupt request to the core.
- irq_vector  out  32  handler address of the accepted source.
- irq_id  out  ID_W  index of the accepted source.
- epc  out  32  PC captured at acceptance.
- irq_active  out  1  high while a handler is in service.

Behaviour:
- Everything is synchronous to the rising edge of clk. rst is synchronous, active-high, and overrides all other inputs.
- Reset values:
  - state = IDLE.
  - mask = 0, gie = 0.
  - pending = 0, irq_q = 0.
  - irq_vector = 0, irq_id = 0, epc = 0.
  - irq_req = 0, irq_active = 0.
- Edge detect:
  - irq_q registers irq_in every cycle.
  - An edge on bit i is irq_in[i] & ~irq_q[i]; it sets pending[i] on that same clock edge.
  - A line held high through reset release counts as an edge on the first post-reset cycle.
- Config register 0:
  - Write: mask <= cfg_wdata[N_IRQ-1:0], gie <= cfg_wdata[31].
  - Read: {gie, zeros, mask}.
- Config register 1 (pending):
  - Write is write-1-to-clear on pending[N_IRQ-1:0].
  - Read returns pending, zero-extended.
- Pending priority on the same bit in the same cycle: a new edge set beats both a W1C clear and an ack clear.
- eligible = pending & mask, qualified by gie. sel = lowest index set in eligible; index 0 has the highest priority.
- FSM:
  - IDLE: if gie and eligible is nonzero, go to REQ.
  - REQ: irq_req = 1; sel is re-evaluated every cycle.
    - If eligible becomes zero (mask/gie write or W1C), return to IDLE; irq_req drops the next cycle. No vector is captured.
    - On irq_ack:
      - irq_id <= sel.
      - irq_vector <= VEC_BASE + (sel << 2).
      - epc <= pc_in.
      - pending[sel] cleared.
      - Go to SERVICE.
  - SERVICE: irq_active = 1, irq_req = 0. Pending keeps accumulating.
    - On irq_ret, go to IDLE.
    - irq_vector, irq_id and epc hold their values until the next ack.
- irq_ack outside REQ and irq_ret outside SERVICE are ignored.
- Latency: an edge sampled at clock k sets pending at k. If gie and mask are set, state is REQ after k+1, so irq_req is high from cycle k+1 onward. An ack at clock m gives valid irq_vector, epc and irq_active after m.
- Back-to-back: irq_ret at clock r goes to IDLE. If anything is still eligible, REQ follows after r+1; IDLE always takes one cycle.
- Vector arithmetic is 32-bit modulo; no overflow flag.
- rst in any state returns to IDLE with all registers reset and discards in-flight service.

Test Plan:
- Reset, write cfg0 = 32'h8000_0001, pulse irq_in[0] at clock 5 -> pending[0] = 1 after 5, irq_req = 1 from cycle 6. Ack at 8 with pc_in = 32'h0000_0040 -> irq_vector = 32'h100, irq_id = 0, epc = 32'h40, pending[0] = 0.
- Priority: mask = 8'hFF, gie = 1, edges on irq_in[5] and irq_in[2] in the same cycle -> first ack gives irq_id = 2, vector 32'h108. After irq_ret, second ack gives irq_id = 5, vector 32'h114.
- Masking: gie = 1, mask = 0, edge on bit 3 -> irq_req stays 0 and cfg1 read = 8'h08. Then write mask = 8'h08 -> irq_req rises one cycle later.
- Withdraw: in REQ for bit 1, W1C pending with 32'h2 -> irq_req = 0 the next cycle. A later irq_ack has no effect and irq_vector is unchanged.
- Service blocking and collision: in SERVICE, edge on bit 4 -> irq_req stays 0 until irq_ret, then rises. Separately, a new edge on bit 0 coinciding with the ack of bit 0 leaves pending[0] = 1.
- Mid-service reset: rst asserted in SERVICE -> next cycle irq_active = 0, epc = 0, pending = 0, mask = 0, gie = 0.

Source files
------------

// File: rtl/irq_sched_if.sv
// ---------------------------------------------------------------------------
// irq_sched_if : signal bundle between the interrupt scheduler and its
// surroundings. The bundle carries the external interrupt lines, the config
// register bus and the request/ack/return handshake with the core sequencer.
//
// Modports
//   slave  : the scheduler side (irq_sched)
//   master : the environment side (core sequencer, config master, irq lines)
//
// Signals
//   irq_in      N_IRQ  raw interrupt lines, rising edge marks a source pending
//   cfg_we      1      config write strobe
//   cfg_addr    1      0 = mask/enable register, 1 = pending register
//   cfg_wdata   32     config write data
//   cfg_rdata   32     config read data (combinational)
//   pc_in       32     current PC from the PC unit
//   irq_ack     1      core accepts the request at an instruction boundary
//   irq_ret     1      core finished the handler
//   irq_req     1      interrupt request to the core
//   irq_vector  32     handler address of the accepted source
//   irq_id      ID_W   index of the accepted source
//   epc         32     PC captured at acceptance
//   irq_active  1      high while a handler is in service
// ---------------------------------------------------------------------------
interface irq_sched_if #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
);
    logic [N_IRQ-1:0] irq_in;
    logic             cfg_we;
    logic             cfg_addr;
    logic [31:0]      cfg_wdata;
    logic [31:0]      cfg_rdata;
    logic [31:0]      pc_in;
    logic             irq_ack;
    logic             irq_ret;
    logic             irq_req;
    logic [31:0]      irq_vector;
    logic [ID_W-1:0]  irq_id;
    logic [31:0]      epc;
    logic             irq_active;

    modport slave (
        input  irq_in, cfg_we, cfg_addr, cfg_wdata, pc_in, irq_ack, irq_ret,
        output cfg_rdata, irq_req, irq_vector, irq_id, epc, irq_active
    );

    modport master (
        output irq_in, cfg_we, cfg_addr, cfg_wdata, pc_in, irq_ack, irq_ret,
        input  cfg_rdata, irq_req, irq_vector, irq_id, epc, irq_active
    );
endinterface

// File: rtl/irq_sched.sv
// ---------------------------------------------------------------------------
// irq_sched : interrupt scheduler for the execution unit.
// Latches rising edges of the interrupt lines as pending bits, qualifies
// them with a mask and a global enable, and requests service for the
// lowest-index eligible source. On acceptance it captures the source id,
// the handler address and the return PC, then blocks further requests until
// the core signals return (no nesting).
//
// Ports
//   clk  in   system clock
//   rst  in   synchronous reset, active-high
//   bus  slave modport of irq_sched_if (irq lines, config bus, handshake)
// ---------------------------------------------------------------------------
module irq_sched #(
    parameter int          N_IRQ    = 8,
    parameter int          ID_W     = 3,
    parameter logic [31:0] VEC_BASE = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    irq_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_SERVICE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N_IRQ-1:0] r_irq_q;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic             r_gie;
    logic [31:0]      r_irq_vector;
    logic [ID_W-1:0]  r_irq_id;
    logic [31:0]      r_epc;
    logic             r_irq_req;
    logic             r_irq_active;

    logic [N_IRQ-1:0] w_edge;
    logic [N_IRQ-1:0] w_eligible;
    logic [N_IRQ-1:0] w_w1c;
    logic [N_IRQ-1:0] w_ack_clr;
    logic [N_IRQ-1:0] w_pending_next;
    logic [ID_W-1:0]  w_sel;
    logic             w_any_eligible;
    logic             w_ack_fire;
    logic [31:0]      w_vector;
    logic [31:0]      w_cfg_rdata;
    logic             w_unused_wdata;

    // Upper config data bits are only partly decoded depending on N_IRQ.
    assign w_unused_wdata = &{1'b0, bus.cfg_wdata};

    assign w_edge         = bus.irq_in & ~r_irq_q;
    assign w_eligible     = r_gie ? (r_pending & r_mask) : '0;
    assign w_any_eligible = |w_eligible;

    // Lowest index wins: scan from the top so the last hit is the smallest.
    always_comb begin
        w_sel = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_sel = ID_W'(i);
            end
        end
    end

    // An ack is only honoured while something is still eligible; a request
    // withdrawn in the same cycle wins over a late ack.
    assign w_ack_fire = (r_state == S_REQ) && w_any_eligible && bus.irq_ack;
    assign w_ack_clr  = w_ack_fire ? (N_IRQ'(1) << w_sel) : '0;
    assign w_w1c      = (bus.cfg_we && bus.cfg_addr) ? bus.cfg_wdata[N_IRQ-1:0] : '0;
    assign w_vector   = VEC_BASE + (32'(w_sel) << 2);

    // A fresh edge on a bit beats any clear of that bit in the same cycle.
    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_pending
            assign w_pending_next[gi] = w_edge[gi] |
                                        (r_pending[gi] & ~w_w1c[gi] & ~w_ack_clr[gi]);
        end
    endgenerate

    always_comb begin
        if (bus.cfg_addr) begin
            w_cfg_rdata = 32'(r_pending);
        end else begin
            w_cfg_rdata     = 32'(r_mask);
            w_cfg_rdata[31] = r_gie;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_irq_q      <= '0;
            r_pending    <= '0;
            r_mask       <= '0;
            r_gie        <= 1'b0;
            r_irq_vector <= '0;
            r_irq_id     <= '0;
            r_epc        <= '0;
            r_irq_req    <= 1'b0;
            r_irq_active <= 1'b0;
        end else begin
            r_irq_q   <= bus.irq_in;
            r_pending <= w_pending_next;
            if (bus.cfg_we && !bus.cfg_addr) begin
                r_mask <= bus.cfg_wdata[N_IRQ-1:0];
                r_gie  <= bus.cfg_wdata[31];
            end

            case (r_state)
                S_IDLE: begin
                    if (w_any_eligible) begin
                        r_state   <= S_REQ;
                        r_irq_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!w_any_eligible) begin
                        r_state   <= S_IDLE;
                        r_irq_req <= 1'b0;
                    end else if (bus.irq_ack) begin
                        r_state      <= S_SERVICE;
                        r_irq_req    <= 1'b0;
                        r_irq_active <= 1'b1;
                        r_irq_id     <= w_sel;
                        r_irq_vector <= w_vector;
                        r_epc        <= bus.pc_in;
                    end
                end
                S_SERVICE: begin
                    if (bus.irq_ret) begin
                        r_state      <= S_IDLE;
                        r_irq_active <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_irq_req    <= 1'b0;
                    r_irq_active <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_rdata  = w_cfg_rdata;
    assign bus.irq_req    = r_irq_req;
    assign bus.irq_vector = r_irq_vector;
    assign bus.irq_id     = r_irq_id;
    assign bus.epc        = r_epc;
    assign bus.irq_active = r_irq_active;

endmodule
